// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Purpose  : Drain stage behind the synchronous BRAM FIFO. A start pulse arms
//            a burst of burst_len_i words. The block pops those words from the
//            FIFO and presents them to the compute core as a valid/ready
//            stream. The final word is tagged with m_last_o. A 2-entry output
//            buffer absorbs the FIFO's 1-cycle read latency so back-pressure
//            never loses a word.
// Ports    : clk_i, rstn_i        - clock, async active-low reset
//            start_i, burst_len_i - burst arm pulse and its length
//            fifo_empty_i, fifo_rd_en_o, fifo_data_i - FIFO read side
//            m_valid_o, m_ready_i, m_data_o, m_last_o - output stream
//            busy_o, done_o, start_drop_o             - status
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 12
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              start_i,
    input  logic [CNT_W-1:0]  burst_len_i,
    input  logic              fifo_empty_i,
    output logic              fifo_rd_en_o,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_last_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              start_drop_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [CNT_W-1:0]  r_rem_issue;   // pops still to be issued
    logic [CNT_W-1:0]  r_rem_out;     // words still to be handed to the core
    logic              r_inflight;    // pop issued last cycle, data arriving now
    logic [1:0]        r_occ;         // output buffer occupancy, 0..2
    logic [DATA_W-1:0] r_buf0;        // buffer head (drives m_data_o)
    logic [DATA_W-1:0] r_buf1;        // buffer second entry
    logic              r_done;
    logic              r_start_drop;

    logic              w_pop;
    logic              w_hs;
    logic              w_rem_out_one;
    logic              w_start_ok;
    logic              w_start_zero;

    // Space check counts the word already in flight so the unconditional
    // capture next cycle always has a free slot. m_ready_i is deliberately
    // left out to keep the consumer off the FIFO read-enable path.
    assign w_pop = (r_state == S_RUN) && !fifo_empty_i && (r_rem_issue != '0)
                   && (({1'b0, r_occ} + {2'b00, r_inflight}) < 3'd2);

    assign m_valid_o     = (r_occ != 2'd0);
    assign w_hs          = m_valid_o && m_ready_i;
    assign w_rem_out_one = (r_rem_out == CNT_W'(1));
    assign m_last_o      = m_valid_o && w_rem_out_one;
    assign m_data_o      = r_buf0;
    assign fifo_rd_en_o  = w_pop;
    assign busy_o        = (r_state != S_IDLE);
    assign done_o        = r_done;
    assign start_drop_o  = r_start_drop;

    assign w_start_ok    = start_i && (r_state == S_IDLE) && (burst_len_i != '0);
    assign w_start_zero  = start_i && (r_state == S_IDLE) && (burst_len_i == '0);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_start_ok) w_state_nxt = S_RUN;
            S_RUN:   if (w_pop && (r_rem_issue == CNT_W'(1))) w_state_nxt = S_FLUSH;
            S_FLUSH: if (w_hs && w_rem_out_one) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Burst counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_rem_issue <= '0;
            r_rem_out   <= '0;
        end else if (w_start_ok) begin
            r_rem_issue <= burst_len_i;
            r_rem_out   <= burst_len_i;
        end else begin
            if (w_pop) begin
                r_rem_issue <= r_rem_issue - CNT_W'(1);
            end
            if (w_hs && (r_rem_out != '0)) begin
                r_rem_out <= r_rem_out - CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Two-entry output buffer. Entry 0 is always the head; a head pop shifts
    // entry 1 forward. A capture lands in the first free slot after any pop
    // taking effect in the same cycle.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_inflight <= 1'b0;
            r_occ      <= 2'd0;
            r_buf0     <= '0;
            r_buf1     <= '0;
        end else begin
            r_inflight <= w_pop;
            case ({r_inflight, w_hs})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_buf0 <= fifo_data_i;
                    end else begin
                        r_buf1 <= fifo_data_i;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    if (r_occ == 2'd1) begin
                        r_buf0 <= fifo_data_i;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= fifo_data_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Status: done pulses after the last handshake, or right after a
    // zero-length start. A start seen while busy is dropped and remembered.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_done       <= 1'b0;
            r_start_drop <= 1'b0;
        end else begin
            r_done <= (w_hs && m_last_o) || w_start_zero;
            if (start_i && (r_state != S_IDLE)) begin
                r_start_drop <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_reader
// Purpose  : Self-checking bench for fifo_burst_reader. A queue models the
//            FIFO (registered read data one cycle after a pop). A reference
//            model tracks the burst by counting pops and handshakes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        rstn;
    logic        start;
    logic [11:0] blen;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_data;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic        m_last;
    logic        busy;
    logic        done;
    logic        start_drop;

    fifo_burst_reader #(.DATA_W(32), .CNT_W(12)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .start_i      (start),
        .burst_len_i  (blen),
        .fifo_empty_i (fifo_empty),
        .fifo_rd_en_o (fifo_rd_en),
        .fifo_data_i  (fifo_data),
        .m_valid_o    (m_valid),
        .m_ready_i    (m_ready),
        .m_data_o     (m_data),
        .m_last_o     (m_last),
        .busy_o       (busy),
        .done_o       (done),
        .start_drop_o (start_drop)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // FIFO model
    logic [31:0] fq[$];
    bit          pend;
    logic [31:0] pend_d;

    // Reference model: burst bookkeeping in words, not in states
    bit mb_busy, mb_drop;
    int m_len, m_issued, m_hs;
    int pop_stamp[$];            // cycle in which each pop of the burst was issued
    // events of the previous cycle, applied at the next edge
    bit ev_rd, ev_hs, ev_start;
    int ev_len;
    // expectations and observations for the current cycle
    bit e_rd, e_valid, e_last, e_busy, e_done;
    logic o_rd, o_valid, o_last, o_busy, o_done, o_drop;
    logic [31:0] o_data;

    task automatic model_clear();
        mb_busy = 0; mb_drop = 0; m_len = 0; m_issued = 0; m_hs = 0;
        pop_stamp.delete();
        ev_rd = 0; ev_hs = 0; ev_start = 0; ev_len = 0;
        e_done = 0;
    endtask

    task automatic do_reset();
        rstn = 1'b0; start = 1'b0; m_ready = 1'b0; fifo_empty = 1'b1; blen = '0;
        fq.delete(); pend = 0;
        model_clear();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // One clock cycle: advance, update the model with last cycle's events,
    // drive inputs on the falling edge, sample outputs, form expectations.
    task automatic cyc_step(input bit rdy, input bit st, input int len);
        int  n_ready;
        bit  was_busy;
        @(posedge clk);
        cyc++;
        e_done   = 0;
        was_busy = mb_busy;
        if (ev_rd) begin
            m_issued++;
            pop_stamp.push_back(cyc - 1);
        end
        if (ev_hs) begin
            m_hs++;
            if (m_hs == m_len) begin
                mb_busy = 0;
                e_done  = 1;
            end
        end
        if (ev_start) begin
            if (was_busy) mb_drop = 1;
            else if (ev_len == 0) e_done = 1;
            else begin
                mb_busy = 1; m_len = ev_len; m_issued = 0; m_hs = 0;
                pop_stamp.delete();
            end
        end
        @(negedge clk);
        if (pend) begin
            fifo_data = pend_d;
            pend = 0;
        end
        fifo_empty = (fq.size() == 0);
        m_ready    = rdy;
        start      = st;
        blen       = 12'(len);
        #1;
        o_rd = fifo_rd_en; o_valid = m_valid; o_last = m_last; o_busy = busy;
        o_done = done; o_drop = start_drop; o_data = m_data;
        // a word is presentable two cycles after its pop
        n_ready = 0;
        foreach (pop_stamp[k]) if (pop_stamp[k] <= cyc - 2) n_ready++;
        e_busy  = mb_busy;
        e_valid = (n_ready > m_hs);
        e_rd    = mb_busy && (fq.size() != 0) && (m_issued < m_len) && ((m_issued - m_hs) < 2);
        e_last  = e_valid && (m_hs == m_len - 1);
        if (o_rd === 1'b1 && fq.size() != 0) begin
            pend   = 1;
            pend_d = fq.pop_front();
        end
        ev_rd    = (o_rd === 1'b1);
        ev_hs    = (o_valid === 1'b1) && rdy;
        ev_start = st;
        ev_len   = len;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, m_data, m_last, busy, done, start_drop} !== 38'd0) begin
            errors++;
            $display("FAIL reset_outputs got=%h exp=0", {fifo_rd_en, m_valid, m_data, m_last, busy, done, start_drop});
        end
        do_reset();
        cyc_step(1'b1, 1'b0, 0);
        checks++;
        if ({o_rd, o_valid, o_data, o_last, o_busy, o_done, o_drop} !== 38'd0) begin
            errors++;
            $display("FAIL reset_release got=%h exp=0", {o_rd, o_valid, o_data, o_last, o_busy, o_done, o_drop});
        end
    endtask

    task automatic test_basic();
        int n_rd = 0, n_done = 0, t_start = 0, t_first = -1;
        logic [31:0] xw[$];
        xw = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        foreach (xw[i]) fq.push_back(xw[i]);
        fq.push_back($urandom); fq.push_back($urandom);
        for (int i = 0; i < 30; i++) begin
            cyc_step(1'b1, i == 0, 4);
            if (i == 0) t_start = cyc;
            if (o_valid === 1'b1 && t_first < 0) t_first = cyc;
            if (o_rd === 1'b1) n_rd++;
            if (o_done === 1'b1) n_done++;
            checks++;
            if ({o_rd, o_valid, o_last, o_busy, o_done, o_drop} !== {e_rd, e_valid, e_last, e_busy, e_done, mb_drop}) begin
                errors++;
                $display("FAIL basic_ctl cyc=%0d rd/val/last/busy/done/drop got=%b exp=%b", cyc,
                         {o_rd, o_valid, o_last, o_busy, o_done, o_drop}, {e_rd, e_valid, e_last, e_busy, e_done, mb_drop});
            end
            if (o_valid === 1'b1) begin
                checks++;
                if (m_hs >= xw.size() || o_data !== xw[m_hs]) begin
                    errors++;
                    $display("FAIL basic_data beat=%0d got=%h exp=%h", m_hs, o_data, (m_hs < xw.size()) ? xw[m_hs] : 32'hx);
                end
            end
        end
        checks++; if (n_rd != 4) begin errors++; $display("FAIL basic_rd_count got=%0d exp=4", n_rd); end
        checks++; if (t_first - t_start != 3) begin errors++; $display("FAIL basic_latency got=%0d exp=3", t_first - t_start); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL basic_done_count got=%0d exp=1", n_done); end
        checks++; if (fq.size() != 2) begin errors++; $display("FAIL basic_extra_words_left got=%0d exp=2", fq.size()); end
        fq.delete();
    endtask

    task automatic test_backpressure();
        int n_rd = 0, n_done = 0;
        bit pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit rdy;
        logic [31:0] xw[$];
        for (int i = 0; i < 8; i++) xw.push_back($urandom);
        foreach (xw[i]) fq.push_back(xw[i]);
        for (int i = 0; i < 60; i++) begin
            rdy = pat[i % 4];
            cyc_step(rdy, i == 0, 8);
            if (o_rd === 1'b1) n_rd++;
            if (o_done === 1'b1) n_done++;
            checks++;
            if ({o_rd, o_valid, o_last, o_busy, o_done, o_drop} !== {e_rd, e_valid, e_last, e_busy, e_done, mb_drop}) begin
                errors++;
                $display("FAIL bp_ctl cyc=%0d rd/val/last/busy/done/drop got=%b exp=%b", cyc,
                         {o_rd, o_valid, o_last, o_busy, o_done, o_drop}, {e_rd, e_valid, e_last, e_busy, e_done, mb_drop});
            end
            if (o_valid === 1'b1 && rdy) begin
                checks++;
                if (m_hs >= xw.size() || o_data !== xw[m_hs]) begin
                    errors++;
                    $display("FAIL bp_data beat=%0d got=%h exp=%h", m_hs, o_data, (m_hs < xw.size()) ? xw[m_hs] : 32'hx);
                end
            end
        end
        checks++; if (n_rd != 8) begin errors++; $display("FAIL bp_rd_count got=%0d exp=8", n_rd); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL bp_done_count got=%0d exp=1", n_done); end
        fq.delete();
    endtask

    task automatic test_fifo_stall();
        int n_rd = 0, n_done = 0, n_stall_valid = 0;
        logic [31:0] xw[$];
        for (int i = 0; i < 5; i++) xw.push_back($urandom);
        fq.push_back(xw[0]); fq.push_back(xw[1]);
        for (int i = 0; i < 40; i++) begin
            if (i == 10) begin
                fq.push_back(xw[2]); fq.push_back(xw[3]); fq.push_back(xw[4]);
            end
            cyc_step(1'b1, i == 0, 5);
            if (i >= 7 && i <= 10 && o_valid === 1'b1) n_stall_valid++;
            if (o_rd === 1'b1) n_rd++;
            if (o_done === 1'b1) n_done++;
            checks++;
            if ({o_rd, o_valid, o_last, o_busy, o_done, o_drop} !== {e_rd, e_valid, e_last, e_busy, e_done, mb_drop}) begin
                errors++;
                $display("FAIL stall_ctl cyc=%0d rd/val/last/busy/done/drop got=%b exp=%b", cyc,
                         {o_rd, o_valid, o_last, o_busy, o_done, o_drop}, {e_rd, e_valid, e_last, e_busy, e_done, mb_drop});
            end
            if (o_valid === 1'b1) begin
                checks++;
                if (m_hs >= xw.size() || o_data !== xw[m_hs]) begin
                    errors++;
                    $display("FAIL stall_data beat=%0d got=%h exp=%h", m_hs, o_data, (m_hs < xw.size()) ? xw[m_hs] : 32'hx);
                end
            end
        end
        checks++; if (n_stall_valid != 0) begin errors++; $display("FAIL stall_valid_while_empty got=%0d exp=0", n_stall_valid); end
        checks++; if (n_rd != 5) begin errors++; $display("FAIL stall_rd_count got=%0d exp=5", n_rd); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL stall_done_count got=%0d exp=1", n_done); end
        fq.delete();
    endtask

    task automatic test_zero_len();
        int n_rd = 0, n_done = 0, t_start = 0, t_done = 0;
        for (int i = 0; i < 3; i++) fq.push_back($urandom);
        for (int i = 0; i < 8; i++) begin
            cyc_step(1'b1, i == 0, 0);
            if (i == 0) t_start = cyc;
            if (o_rd === 1'b1 || o_valid === 1'b1) n_rd++;
            if (o_done === 1'b1) begin n_done++; t_done = cyc; end
            checks++;
            if ({o_rd, o_valid, o_last, o_busy, o_done, o_drop} !== {e_rd, e_valid, e_last, e_busy, e_done, mb_drop}) begin
                errors++;
                $display("FAIL zero_ctl cyc=%0d rd/val/last/busy/done/drop got=%b exp=%b", cyc,
                         {o_rd, o_valid, o_last, o_busy, o_done, o_drop}, {e_rd, e_valid, e_last, e_busy, e_done, mb_drop});
            end
        end
        checks++; if (n_rd != 0) begin errors++; $display("FAIL zero_activity got=%0d exp=0", n_rd); end
        checks++; if (n_done != 1 || t_done != t_start + 1) begin
            errors++; $display("FAIL zero_done count=%0d at=%0d exp count=1 at=%0d", n_done, t_done, t_start + 1);
        end
        checks++; if (fq.size() != 3) begin errors++; $display("FAIL zero_fifo_untouched got=%0d exp=3", fq.size()); end
        fq.delete();
    endtask

    task automatic test_start_drop();
        int n_rd = 0, n_done = 0, n_hs = 0;
        bit rdy;
        logic [31:0] xw[$];
        for (int i = 0; i < 6; i++) xw.push_back($urandom);
        foreach (xw[i]) fq.push_back(xw[i]);
        fq.push_back($urandom);
        for (int i = 0; i < 80; i++) begin
            rdy = 1'($urandom_range(0, 1));
            cyc_step(rdy, (i == 0) || (i == 4), (i == 4) ? 3 : 6);
            if (o_rd === 1'b1) n_rd++;
            if (o_done === 1'b1) n_done++;
            checks++;
            if ({o_rd, o_valid, o_last, o_busy, o_done, o_drop} !== {e_rd, e_valid, e_last, e_busy, e_done, mb_drop}) begin
                errors++;
                $display("FAIL drop_ctl cyc=%0d rd/val/last/busy/done/drop got=%b exp=%b", cyc,
                         {o_rd, o_valid, o_last, o_busy, o_done, o_drop}, {e_rd, e_valid, e_last, e_busy, e_done, mb_drop});
            end
            if (o_valid === 1'b1 && rdy) begin
                n_hs++;
                checks++;
                if (m_hs >= xw.size() || o_data !== xw[m_hs]) begin
                    errors++;
                    $display("FAIL drop_data beat=%0d got=%h exp=%h", m_hs, o_data, (m_hs < xw.size()) ? xw[m_hs] : 32'hx);
                end
            end
        end
        checks++; if (o_drop !== 1'b1) begin errors++; $display("FAIL drop_sticky got=%b exp=1", o_drop); end
        checks++; if (n_hs != 6 || n_rd != 6) begin errors++; $display("FAIL drop_word_count beats=%0d pops=%0d exp=6", n_hs, n_rd); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL drop_done_count got=%0d exp=1", n_done); end
        fq.delete();
    endtask

    task automatic test_reset_mid();
        int n_rd = 0, n_done = 0, n_hs = 0;
        logic [31:0] xw[$];
        for (int i = 0; i < 6; i++) fq.push_back($urandom);
        for (int i = 0; i < 30 && n_hs < 3; i++) begin
            cyc_step(1'b1, i == 0, 6);
            if (o_valid === 1'b1) n_hs++;
        end
        checks++; if (n_hs != 3) begin errors++; $display("FAIL rstmid_reach3 got=%0d exp=3", n_hs); end
        rstn = 1'b0;
        #1;
        checks++;
        if ({fifo_rd_en, m_valid, m_data, m_last, busy, done, start_drop} !== 38'd0) begin
            errors++;
            $display("FAIL rstmid_outputs got=%h exp=0", {fifo_rd_en, m_valid, m_data, m_last, busy, done, start_drop});
        end
        do_reset();
        for (int i = 0; i < 2; i++) xw.push_back($urandom);
        foreach (xw[i]) fq.push_back(xw[i]);
        fq.push_back($urandom);
        n_hs = 0;
        for (int i = 0; i < 20; i++) begin
            cyc_step(1'b1, i == 0, 2);
            if (o_rd === 1'b1) n_rd++;
            if (o_done === 1'b1) n_done++;
            checks++;
            if ({o_rd, o_valid, o_last, o_busy, o_done, o_drop} !== {e_rd, e_valid, e_last, e_busy, e_done, mb_drop}) begin
                errors++;
                $display("FAIL rstmid_ctl cyc=%0d rd/val/last/busy/done/drop got=%b exp=%b", cyc,
                         {o_rd, o_valid, o_last, o_busy, o_done, o_drop}, {e_rd, e_valid, e_last, e_busy, e_done, mb_drop});
            end
            if (o_valid === 1'b1) begin
                n_hs++;
                checks++;
                if (m_hs >= xw.size() || o_data !== xw[m_hs]) begin
                    errors++;
                    $display("FAIL rstmid_data beat=%0d got=%h exp=%h", m_hs, o_data, (m_hs < xw.size()) ? xw[m_hs] : 32'hx);
                end
            end
        end
        checks++; if (n_rd != 2 || n_hs != 2) begin errors++; $display("FAIL rstmid_counts pops=%0d beats=%0d exp=2", n_rd, n_hs); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL rstmid_done_count got=%0d exp=1", n_done); end
        checks++; if (fq.size() != 1) begin errors++; $display("FAIL rstmid_extra_words_left got=%0d exp=1", fq.size()); end
        fq.delete();
    endtask

    initial begin
        rstn = 1'b0; start = 1'b0; blen = '0; fifo_empty = 1'b1;
        fifo_data = '0; m_ready = 1'b0; pend = 0;
        model_clear();
        test_reset();
        test_basic();
        test_backpressure();
        test_fifo_stall();
        test_zero_len();
        test_start_drop();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
